seq_chunked_adder: RTL



---
 rtl/seq_adder_pkg.sv | 21 ++
 rtl/seq_chunked_adder_add_slice.sv | 24 ++
 rtl/seq_chunked_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
package seq_adder_pkg;

   // Controller states: idle, processing slices, presenting the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of N-bit slices needed to cover W bits.
   function automatic int calc_slices(input int w, input int n);
      return w / n;
   endfunction

   // Slice counter width; a single-slice adder still gets a 1-bit counter.
   function automatic int calc_cnt_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/seq_chunked_adder_add_slice.sv
// Combinational N-bit adder slice. Besides sum and carry-out it exposes the
// carry into the slice MSB so the top level can form two's-complement overflow.
module add_slice #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   logic [N:0] full;

   // One wide addition; the MSB carry-in is recovered from the MSB sum bit.
   always_comb begin
      full  = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      sum   = full[N-1:0];
      cout  = full[N];
      c_msb = a[N-1] ^ b[N-1] ^ full[N-1];
   end

endmodule

// File: rtl/seq_chunked_adder.sv
// Multi-cycle W-bit adder: one N-bit slice per cycle, carry held in a register
// between slices, result assembled in place in the sum register.
module seq_chunked_adder
   import seq_adder_pkg::*;
#(
   parameter int W      = 64,
   parameter int N      = 16,
   parameter int SIGNED = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         v
);

   localparam int K  = calc_slices(W, N);
   localparam int CW = calc_cnt_width(K);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   if (W % N != 0) begin : g_bad_split
      $error("seq_chunked_adder: W must be a multiple of N");
   end

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           carry_q, carry_d, cout_q, cout_d, v_q, v_d;

   logic [N-1:0]   sl_a, sl_b, sl_sum;
   logic           sl_cout, sl_cmsb;
   int             base;

   // Select the operand slice addressed by the counter.
   always_comb begin
      base = int'(cnt_q) * N;
      sl_a = a_q[base +: N];
      sl_b = b_q[base +: N];
   end

   add_slice #(.N(N)) u_slice (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (carry_q),
      .sum   (sl_sum),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   // Next-state and datapath update for the IDLE/RUN/DONE controller.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      v_d     = v_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[base +: N] = sl_sum;
            carry_d          = sl_cout;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = sl_cout;
               v_d     = (SIGNED != 0) ? (sl_cmsb ^ sl_cout) : sl_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand, carry, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         v_q     <= v_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign v    = v_q;

endmodule
